// File: rtl/mctrl_pkg.sv
// mctrl_pkg: shared types and encodings for the multi-cycle MIPS-subset
// control FSM. The ALUOp values are consumed by the existing ALU controller
// and must stay in sync with it.
package mctrl_pkg;

   localparam int unsigned OP_W    = 6;   // opcode width (instr[31:26])
   localparam int unsigned ALUOP_W = 3;   // ALUOp width, matches ALU controller
   localparam int unsigned CNT_W   = 32;  // performance counter width
   localparam int unsigned SRCB_W  = 2;
   localparam int unsigned PCSRC_W = 2;

   typedef enum logic [3:0] {
      IDLE,
      FETCH,
      DECODE,
      MEM_ADDR,
      MEM_RD,
      MEM_WB,
      MEM_WR,
      R_EXEC,
      R_WB,
      I_EXEC,
      I_WB,
      BRANCH,
      JUMP
   } state_e;

   // Supported opcodes
   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_SLTIU = 6'b001011;
   localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
   localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;

   // ALUOp encoding shared with the ALU controller
   localparam logic [ALUOP_W-1:0] ALUOP_RTYPE = 3'b000;
   localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b001;
   localparam logic [ALUOP_W-1:0] ALUOP_SLTIU = 3'b010;
   localparam logic [ALUOP_W-1:0] ALUOP_BEQ   = 3'b011;
   localparam logic [ALUOP_W-1:0] ALUOP_LUI   = 3'b100;
   localparam logic [ALUOP_W-1:0] ALUOP_ORI   = 3'b101;
   localparam logic [ALUOP_W-1:0] ALUOP_BNE   = 3'b110;

   // ALU operand B select
   localparam logic [SRCB_W-1:0] SRCB_RT      = 2'b00;
   localparam logic [SRCB_W-1:0] SRCB_FOUR    = 2'b01;
   localparam logic [SRCB_W-1:0] SRCB_IMM     = 2'b10;
   localparam logic [SRCB_W-1:0] SRCB_IMM_SH2 = 2'b11;

   // PC source select
   localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 2'b00;
   localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'b10;

   // True for every opcode the datapath can execute
   function automatic logic op_legal(input logic [OP_W-1:0] op);
      logic ok;
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_SLTIU,
         OP_LUI, OP_ORI, OP_BEQ, OP_BNE, OP_J: ok = 1'b1;
         default:                             ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mctrl_out_decode.sv
// mctrl_out_decode: combinational map from (state, opcode, mem_ready) to the
// datapath control signals. Pure Moore decode of state, except that FETCH
// gates ir_write/pc_write with mem_ready_i and DECODE flags illegal opcodes.
// Ports: state_i, opcode_i, mem_ready_i in; all control strobes/selects out.
module mctrl_out_decode
   import mctrl_pkg::*;
(
   input  state_e                 state_i,
   input  logic [OP_W-1:0]        opcode_i,
   input  logic                   mem_ready_i,
   output logic                   pc_write_o,
   output logic                   pc_write_cond_o,
   output logic                   iord_o,
   output logic                   mem_read_o,
   output logic                   mem_write_o,
   output logic                   ir_write_o,
   output logic                   mem_to_reg_o,
   output logic                   reg_dst_o,
   output logic                   reg_write_o,
   output logic                   alu_src_a_o,
   output logic [SRCB_W-1:0]      alu_src_b_o,
   output logic [ALUOP_W-1:0]     alu_op_o,
   output logic [PCSRC_W-1:0]     pc_source_o,
   output logic                   illegal_o
);

   // Control decode; every output defaults to 0 (IDLE and reset state)
   always_comb begin
      pc_write_o      = 1'b0;
      pc_write_cond_o = 1'b0;
      iord_o          = 1'b0;
      mem_read_o      = 1'b0;
      mem_write_o     = 1'b0;
      ir_write_o      = 1'b0;
      mem_to_reg_o    = 1'b0;
      reg_dst_o       = 1'b0;
      reg_write_o     = 1'b0;
      alu_src_a_o     = 1'b0;
      alu_src_b_o     = SRCB_RT;
      alu_op_o        = ALUOP_RTYPE;
      pc_source_o     = PCSRC_ALU;
      illegal_o       = 1'b0;
      case (state_i)
         FETCH: begin
            mem_read_o  = 1'b1;
            alu_src_b_o = SRCB_FOUR;
            alu_op_o    = ALUOP_ADD;
            // IR and PC+4 only commit on the cycle the read completes
            ir_write_o  = mem_ready_i;
            pc_write_o  = mem_ready_i;
         end
         DECODE: begin
            alu_src_b_o = SRCB_IMM_SH2;
            alu_op_o    = ALUOP_ADD;
            illegal_o   = ~op_legal(opcode_i);
         end
         MEM_ADDR: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SRCB_IMM;
            alu_op_o    = ALUOP_ADD;
         end
         MEM_RD: begin
            mem_read_o = 1'b1;
            iord_o     = 1'b1;
         end
         MEM_WB: begin
            reg_write_o  = 1'b1;
            mem_to_reg_o = 1'b1;
         end
         MEM_WR: begin
            mem_write_o = 1'b1;
            iord_o      = 1'b1;
         end
         R_EXEC: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = ALUOP_RTYPE;
         end
         R_WB: begin
            reg_write_o = 1'b1;
            reg_dst_o   = 1'b1;
         end
         I_EXEC: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = SRCB_IMM;
            case (opcode_i)
               OP_SLTIU: alu_op_o = ALUOP_SLTIU;
               OP_LUI:   alu_op_o = ALUOP_LUI;
               OP_ORI:   alu_op_o = ALUOP_ORI;
               default:  alu_op_o = ALUOP_ADD;
            endcase
         end
         I_WB: begin
            reg_write_o = 1'b1;
         end
         BRANCH: begin
            alu_src_a_o     = 1'b1;
            pc_write_cond_o = 1'b1;
            pc_source_o     = PCSRC_ALUOUT;
            alu_op_o        = (opcode_i == OP_BNE) ? ALUOP_BNE : ALUOP_BEQ;
         end
         JUMP: begin
            pc_write_o  = 1'b1;
            pc_source_o = PCSRC_JUMP;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM of the multi-cycle MIPS-subset datapath.
// Sequences FETCH/DECODE/execute/memory/writeback; memory accesses wait on
// mem_ready_i so variable-latency memory is tolerated.
// Ports: clk_i, rst_i (async, active-low), opcode_i, mem_ready_i in;
//        datapath controls and illegal_o out (decoded from state).
// Optional: define MCTRL_PERF_CNT_EN to add cycle_cnt_o, instr_cnt_o and
//           stall_cnt_o performance counters.
module multicycle_ctrl
   import mctrl_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [OP_W-1:0]        opcode_i,
   input  logic                   mem_ready_i,
   output logic                   pc_write_o,
   output logic                   pc_write_cond_o,
   output logic                   iord_o,
   output logic                   mem_read_o,
   output logic                   mem_write_o,
   output logic                   ir_write_o,
   output logic                   mem_to_reg_o,
   output logic                   reg_dst_o,
   output logic                   reg_write_o,
   output logic                   alu_src_a_o,
   output logic [SRCB_W-1:0]      alu_src_b_o,
   output logic [ALUOP_W-1:0]     alu_op_o,
   output logic [PCSRC_W-1:0]     pc_source_o,
   output logic                   illegal_o
`ifdef MCTRL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]       cycle_cnt_o,
   output logic [CNT_W-1:0]       instr_cnt_o,
   output logic [CNT_W-1:0]       stall_cnt_o
`endif
);

   state_e state_q, state_d;

   // State register; reset forces IDLE so every decoded output drops at once
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     state_d = FETCH;
         FETCH:    if (mem_ready_i) state_d = DECODE;
         DECODE: begin
            case (opcode_i)
               OP_RTYPE:                         state_d = R_EXEC;
               OP_LW, OP_SW:                     state_d = MEM_ADDR;
               OP_ADDI, OP_SLTIU, OP_LUI, OP_ORI: state_d = I_EXEC;
               OP_BEQ, OP_BNE:                   state_d = BRANCH;
               OP_J:                             state_d = JUMP;
               default:                          state_d = FETCH;
            endcase
         end
         MEM_ADDR: state_d = (opcode_i == OP_LW) ? MEM_RD : MEM_WR;
         MEM_RD:   if (mem_ready_i) state_d = MEM_WB;
         MEM_WB:   state_d = FETCH;
         MEM_WR:   if (mem_ready_i) state_d = FETCH;
         R_EXEC:   state_d = R_WB;
         R_WB:     state_d = FETCH;
         I_EXEC:   state_d = I_WB;
         I_WB:     state_d = FETCH;
         BRANCH:   state_d = FETCH;
         JUMP:     state_d = FETCH;
         default:  state_d = IDLE;
      endcase
   end

   mctrl_out_decode u_out_decode (
      .state_i         (state_q),
      .opcode_i        (opcode_i),
      .mem_ready_i     (mem_ready_i),
      .pc_write_o      (pc_write_o),
      .pc_write_cond_o (pc_write_cond_o),
      .iord_o          (iord_o),
      .mem_read_o      (mem_read_o),
      .mem_write_o     (mem_write_o),
      .ir_write_o      (ir_write_o),
      .mem_to_reg_o    (mem_to_reg_o),
      .reg_dst_o       (reg_dst_o),
      .reg_write_o     (reg_write_o),
      .alu_src_a_o     (alu_src_a_o),
      .alu_src_b_o     (alu_src_b_o),
      .alu_op_o        (alu_op_o),
      .pc_source_o     (pc_source_o),
      .illegal_o       (illegal_o)
   );

`ifdef MCTRL_PERF_CNT_EN
   logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q, stall_cnt_q;
   logic             instr_done_c, stall_c;

   // An instruction retires when a completing state hands back to FETCH;
   // IDLE->FETCH and illegal DECODE->FETCH are not retirements
   assign instr_done_c = (state_d == FETCH) &&
                         (state_q inside {MEM_WB, MEM_WR, R_WB, I_WB, BRANCH, JUMP});
   assign stall_c      = (state_q inside {FETCH, MEM_RD, MEM_WR}) && !mem_ready_i;

   // Free-running, wrapping performance counters
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cycle_cnt_q <= '0;
         instr_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (state_q != IDLE) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
         if (instr_done_c)    instr_cnt_q <= instr_cnt_q + CNT_W'(1);
         if (stall_c)         stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

   assign cycle_cnt_o = cycle_cnt_q;
   assign instr_cnt_o = instr_cnt_q;
   assign stall_cnt_o = stall_cnt_q;
`endif

   // Unified memory takes one request at a time
   a_mem_excl: assert property (@(posedge clk_i) disable iff (!rst_i)
                                !(mem_read_o && mem_write_o));

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl. Each instruction
// pushes its expected per-cycle control vector (plus the opcode and memory
// ready to drive) into a queue; the driver pops one entry per cycle.
module tb_multicycle_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [5:0] opcode_i;
   logic       mem_ready_i;
   logic       pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o;
   logic       ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o;
   logic [1:0] alu_src_b_o;
   logic [2:0] alu_op_o;
   logic [1:0] pc_source_o;
   logic       illegal_o;
`ifdef MCTRL_PERF_CNT_EN
   logic [31:0] cycle_cnt_o, instr_cnt_o, stall_cnt_o;
`endif

   multicycle_ctrl dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .opcode_i        (opcode_i),
      .mem_ready_i     (mem_ready_i),
      .pc_write_o      (pc_write_o),
      .pc_write_cond_o (pc_write_cond_o),
      .iord_o          (iord_o),
      .mem_read_o      (mem_read_o),
      .mem_write_o     (mem_write_o),
      .ir_write_o      (ir_write_o),
      .mem_to_reg_o    (mem_to_reg_o),
      .reg_dst_o       (reg_dst_o),
      .reg_write_o     (reg_write_o),
      .alu_src_a_o     (alu_src_a_o),
      .alu_src_b_o     (alu_src_b_o),
      .alu_op_o        (alu_op_o),
      .pc_source_o     (pc_source_o),
      .illegal_o       (illegal_o)
`ifdef MCTRL_PERF_CNT_EN
      ,
      .cycle_cnt_o     (cycle_cnt_o),
      .instr_cnt_o     (instr_cnt_o),
      .stall_cnt_o     (stall_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string       tag;
      logic [5:0]  op;
      logic        rdy;
      logic [17:0] exp;
      bit          fin;   // last cycle of a retiring instruction
      bit          stl;   // memory wait cycle with ready low
   } ent_t;

   ent_t q[$];
   int   n_total = 0;
   int   n_bad   = 0;
   int   m_cyc = 0, m_ins = 0, m_stl = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Control vector: pcw pcwc iord mr mw irw m2r rdst rw sa sb[2] op[3] ps[2] ill
   function automatic logic [17:0] cv(input logic pcw, pcwc, iord, mr, mw, irw,
                                      m2r, rdst, rw, sa, input logic [1:0] sb,
                                      input logic [2:0] op, input logic [1:0] ps,
                                      input logic ill);
      return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, sa, sb, op, ps, ill};
   endfunction

   function automatic logic [17:0] outv();
      return {pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o,
              ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o,
              alu_src_b_o, alu_op_o, pc_source_o, illegal_o};
   endfunction

   task automatic push(input string tag, input logic [5:0] op, input logic rdy,
                       input logic [17:0] exp, input bit fin, input bit stl);
      ent_t e;
      e.tag = tag; e.op = op; e.rdy = rdy; e.exp = exp; e.fin = fin; e.stl = stl;
      q.push_back(e);
   endtask

   // Ready is a don't-care outside FETCH/MEM_RD/MEM_WR, so randomise it there
   function automatic logic rx();
      return 1'($urandom_range(0, 1));
   endfunction

   // Expected cycle sequence of one instruction: fw fetch waits, dw data waits
   task automatic instr(input string tag, input logic [5:0] op, input int fw, input int dw);
      logic       ill;
      logic [2:0] aop;
      for (int i = 0; i < fw; i++)
         push({tag, "/fetch_w"}, op, 1'b0, cv(0,0,0,1,0,0,0,0,0,0,2'b01,3'b001,2'b00,0), 0, 1);
      push({tag, "/fetch"}, op, 1'b1, cv(1,0,0,1,0,1,0,0,0,0,2'b01,3'b001,2'b00,0), 0, 0);
      ill = !(op inside {6'h00, 6'h23, 6'h2b, 6'h08, 6'h0b, 6'h0f, 6'h0d, 6'h04, 6'h05, 6'h02});
      push({tag, "/decode"}, op, rx(), cv(0,0,0,0,0,0,0,0,0,0,2'b11,3'b001,2'b00,ill), 0, 0);
      case (op)
         6'h00: begin
            push({tag, "/rexec"}, op, rx(), cv(0,0,0,0,0,0,0,0,0,1,2'b00,3'b000,2'b00,0), 0, 0);
            push({tag, "/rwb"},   op, rx(), cv(0,0,0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00,0), 1, 0);
         end
         6'h23, 6'h2b: begin
            push({tag, "/maddr"}, op, rx(), cv(0,0,0,0,0,0,0,0,0,1,2'b10,3'b001,2'b00,0), 0, 0);
            if (op == 6'h23) begin
               for (int i = 0; i < dw; i++)
                  push({tag, "/mrd_w"}, op, 1'b0, cv(0,0,1,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0), 0, 1);
               push({tag, "/mrd"}, op, 1'b1, cv(0,0,1,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0), 0, 0);
               push({tag, "/mwb"}, op, rx(), cv(0,0,0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,0), 1, 0);
            end else begin
               for (int i = 0; i < dw; i++)
                  push({tag, "/mwr_w"}, op, 1'b0, cv(0,0,1,0,1,0,0,0,0,0,2'b00,3'b000,2'b00,0), 0, 1);
               push({tag, "/mwr"}, op, 1'b1, cv(0,0,1,0,1,0,0,0,0,0,2'b00,3'b000,2'b00,0), 1, 0);
            end
         end
         6'h08, 6'h0b, 6'h0f, 6'h0d: begin
            aop = (op == 6'h0b) ? 3'b010 : (op == 6'h0f) ? 3'b100 :
                  (op == 6'h0d) ? 3'b101 : 3'b001;
            push({tag, "/iexec"}, op, rx(), cv(0,0,0,0,0,0,0,0,0,1,2'b10,aop,2'b00,0), 0, 0);
            push({tag, "/iwb"},   op, rx(), cv(0,0,0,0,0,0,0,0,1,0,2'b00,3'b000,2'b00,0), 1, 0);
         end
         6'h04, 6'h05: begin
            aop = (op == 6'h05) ? 3'b110 : 3'b011;
            push({tag, "/branch"}, op, rx(), cv(0,1,0,0,0,0,0,0,0,1,2'b00,aop,2'b01,0), 1, 0);
         end
         6'h02:
            push({tag, "/jump"}, op, rx(), cv(1,0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,0), 1, 0);
         default: ;
      endcase
   endtask

   task automatic chk_cnt(input string tag);
`ifdef MCTRL_PERF_CNT_EN
      chk({tag, "/cycle_cnt"}, cycle_cnt_o, 32'(m_cyc));
      chk({tag, "/instr_cnt"}, instr_cnt_o, 32'(m_ins));
      chk({tag, "/stall_cnt"}, stall_cnt_o, 32'(m_stl));
`else
      if (tag.len() < 0) $display("%s", tag);
`endif
   endtask

   // Pop up to n entries, one per clock; counters checked on the final entry
   task automatic run_n(input int n);
      ent_t e;
      for (int i = 0; i < n && q.size() > 0; i++) begin
         @(negedge clk_i);
         e = q.pop_front();
         opcode_i    = e.op;
         mem_ready_i = e.rdy;
         #1;
         chk(e.tag, 32'(outv()), 32'(e.exp));
         if (q.size() == 0) chk_cnt("end");
         m_cyc++;
         if (e.fin) m_ins++;
         if (e.stl) m_stl++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", n_total, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i       = 1'b0;
      opcode_i    = 6'h00;
      mem_ready_i = 1'b1;
      repeat (3) @(negedge clk_i);
      #1;
      chk("rst_hold", 32'(outv()), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      chk("idle", 32'(outv()), 32'd0);
      chk_cnt("idle");

      instr("rtype", 6'h00, 0, 0);
      instr("lw_w2", 6'h23, 0, 2);
      instr("bne",   6'h05, 0, 0);
      instr("illeg", 6'h3f, 0, 0);
      instr("addi",  6'h08, 1, 0);
      instr("sltiu", 6'h0b, 2, 0);
      instr("lui",   6'h0f, 0, 0);
      instr("ori",   6'h0d, 0, 0);
      instr("sw_w1", 6'h2b, 0, 1);
      instr("beq",   6'h04, 0, 0);
      instr("j",     6'h02, 0, 0);
      instr("lw_w0", 6'h23, 1, 0);
      instr("tail",  6'h00, 0, 0);
      run_n(q.size());

      // Abandon a store waiting in MEM_WR via asynchronous reset
      instr("sw_rst", 6'h2b, 0, 6);
      run_n(6);
      #2;
      rst_i = 1'b0;
      #1;
      chk("rst_async", 32'(outv()), 32'd0);
      chk("rst_async/mem_write", 32'(mem_write_o), 32'd0);
      q.delete();
      m_cyc = 0; m_ins = 0; m_stl = 0;
      chk_cnt("rst_async");
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      chk("idle2", 32'(outv()), 32'd0);

      instr("j2",  6'h02, 0, 0);
      instr("r2",  6'h00, 1, 0);
      instr("fin", 6'h2b, 0, 0);
      run_n(q.size());

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multi-cycle MIPS-subset datapath. It sequences the shared ALU, register file, unified memory and PC across fetch, decode, execute, memory and writeback steps. It drives the 3-bit ALUOp consumed by the existing ALU controller, using the same encoding. Memory accesses use a ready handshake, so variable-latency memory is tolerated.

Parameters:
OP_W, 6, opcode width
ALUOP_W, 3, ALUOp width; must match the ALU controller
CNT_W, 32, performance counter width (optional feature only)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
opcode_i  in  6  instr[31:26] from IR; valid from DECODE onward
mem_ready_i  in  1  memory completes the current read/write this cycle
pc_write_o  out  1  unconditional PC load
pc_write_cond_o  out  1  PC load qualified by ALU zero (beq) or ~zero (bne)
iord_o  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
mem_read_o  out  1  memory read request
mem_write_o  out  1  memory write request
ir_write_o  out  1  IR load
mem_to_reg_o  out  1  writeback source: 0 = ALUOut, 1 = MDR
reg_dst_o  out  1  0 = rt, 1 = rd
reg_write_o  out  1  register file write enable
alu_src_a_o  out  1  0 = PC, 1 = rs
alu_src_b_o  out  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
alu_op_o  out  3  000 R-type, 001 add, 010 sltiu, 011 beq, 100 lui, 101 ori, 110 bne
pc_source_o  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
illegal_o  out  1  one-cycle pulse on an unsupported opcode

Behaviour:
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP.
- rst_i low: state = IDLE immediately; every output 0. IDLE → FETCH on the first rising edge after release.
- Outputs are a Moore decode of state, except the qualifications below.
- FETCH:
  - mem_read = 1, iord = 0, src_a = 0, src_b = 01, alu_op = 001, pc_source = 00.
  - ir_write and pc_write assert only in the cycle where mem_ready_i = 1; that cycle also moves to DECODE.
  - Otherwise the FSM holds in FETCH.
- DECODE: src_a = 0, src_b = 11, alu_op = 001 (branch target into ALUOut). Next state by opcode:
  - 000000 → R_EXEC
  - 100011 / 101011 (lw/sw) → MEM_ADDR
  - 001000 / 001011 / 001111 / 001101 (addi/sltiu/lui/ori) → I_EXEC
  - 000100 / 000101 (beq/bne) → BRANCH
  - 000010 (j) → JUMP
  - anything else → FETCH with illegal_o = 1 for that cycle and no architectural write.
- MEM_ADDR: src_a = 1, src_b = 10, alu_op = 001; lw → MEM_RD, sw → MEM_WR.
- MEM_RD: mem_read = 1, iord = 1; hold until mem_ready_i, then → MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0; → FETCH.
- MEM_WR: mem_write = 1, iord = 1; hold until mem_ready_i, then → FETCH.
- R_EXEC: src_a = 1, src_b = 00, alu_op = 000; → R_WB. R_WB: reg_write = 1, reg_dst = 1; → FETCH.
- I_EXEC: src_a = 1, src_b = 10, alu_op = 001 / 010 / 100 / 101 for addi / sltiu / lui / ori; → I_WB.
- I_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0; → FETCH.
- BRANCH: src_a = 1, src_b = 00, pc_write_cond = 1, pc_source = 01, alu_op = 011 (beq) / 110 (bne); → FETCH.
- JUMP: pc_write = 1, pc_source = 10; → FETCH.
- Latency, with zero memory wait (mem_ready_i high on first request): R/I-type 4, lw 5, sw 4, branch 3, jump 3 cycles. Each cycle mem_ready_i is held low adds one cycle in the waiting state.
- mem_ready_i is ignored outside FETCH, MEM_RD and MEM_WR.
- opcode_i is sampled in DECODE, I_EXEC, BRANCH and MEM_ADDR. The IR is stable over those states because ir_write is 0 outside FETCH.
- Reset asserted mid-instruction: immediate return to IDLE, all outputs 0. A partial memory request is abandoned; memory must tolerate a dropped request.
- mem_read and mem_write are never both 1 in the same cycle. Verify with an assertion.

Optional Feature:
MCTRL_PERF_CNT_EN
- Defined: adds outputs cycle_cnt_o[CNT_W], instr_cnt_o[CNT_W] and stall_cnt_o[CNT_W], all reset to 0.
  - cycle_cnt_o counts every cycle not in IDLE.
  - instr_cnt_o counts every transition into FETCH from a completing state; illegal returns are excluded.
  - stall_cnt_o counts cycles waiting with mem_ready_i = 0.
  - All three wrap modulo 2^CNT_W.
- Undefined: the ports and the counter logic do not exist.

Decomposition:
- Package mctrl_pkg:
  - state enum
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_SLTIU, OP_LUI, OP_ORI, OP_BEQ, OP_BNE, OP_J)
  - ALUOp localparams, shared with the ALU controller
  - ALUSrcB and PCSource encodings
- Sub-module mctrl_out_decode: combinational map from (state, opcode, mem_ready) to all control outputs. The top module keeps the state register, next-state logic and counters.

Test Plan:
- Reset: hold rst_i = 0, then release → all outputs 0 in IDLE; FETCH on the next edge with mem_read = 1, src_b = 01, alu_op = 001.
- R-type (opcode 000000), mem_ready_i tied 1 → states FETCH, DECODE, R_EXEC, R_WB; reg_write = 1 and reg_dst = 1 only in cycle 4; alu_op = 000 in cycle 3.
- lw (100011), mem_ready_i low 2 cycles in MEM_RD → 7 cycles total; reg_write = 1 with mem_to_reg = 1 exactly once.
- bne (000101) → BRANCH with alu_op = 110, pc_write_cond = 1, pc_source = 01; back in FETCH 3 cycles after the start.
- Illegal opcode 111111 → illegal_o pulses 1 cycle in DECODE; next state FETCH; reg_write, mem_write and pc_write stay 0.
- rst_i dropped while in MEM_WR with mem_ready_i = 0 → mem_write falls to 0 asynchronously; IDLE after release; instr_cnt_o = 0 when MCTRL_PERF_CNT_EN is defined.
